// File: rtl/branch_pkg.sv
// Shared encodings for the ID-stage branch sequencer: branch types, compare
// relations, FSM states and the per-operand hazard stall helper.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLEZ = 3'b011,
    BR_BGTZ = 3'b100,
    BR_BLTZ = 3'b101
  } br_type_e;

  typedef enum logic [1:0] {
    REL_LT = 2'b00,
    REL_EQ = 2'b01,
    REL_GT = 2'b10
  } rel_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_STALL   = 2'b01,
    S_RESOLVE = 2'b10
  } state_e;

  // Cycles an operand must wait: an EX load needs two, an EX ALU result or a MEM load one.
  function automatic logic [1:0] operand_stalls(
    input logic [4:0] r,
    input logic       ex_regwrite,
    input logic       ex_memread,
    input logic [4:0] ex_rd,
    input logic       mem_memread,
    input logic [4:0] mem_rd
  );
    logic [1:0] n;
    n = 2'd0;
    if (r != 5'd0) begin
      if (ex_regwrite && (ex_rd == r)) n = ex_memread ? 2'd2 : 2'd1;
      else if (mem_memread && (mem_rd == r)) n = 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// ID-stage operand/hazard inputs and PC/IF-ID control outputs of the branch sequencer.
// The statistics counters exist only when BRANCH_STATS_EN is defined.
interface branch_sequencer_if #(parameter int XLEN = 32);

  logic            i_hold;
  logic [2:0]      i_id_branch;
  logic [4:0]      i_id_rs;
  logic [4:0]      i_id_rt;
  logic [XLEN-1:0] i_rs_data;
  logic [XLEN-1:0] i_rt_data;
  logic [XLEN-1:0] i_id_pc_plus4;
  logic [XLEN-1:0] i_id_imm;
  logic            i_ex_regwrite;
  logic            i_ex_memread;
  logic [4:0]      i_ex_rd;
  logic            i_mem_memread;
  logic [4:0]      i_mem_rd;
  logic            o_stall;
  logic            o_pc_sel;
  logic            o_flush;
  logic [XLEN-1:0] o_target;
`ifdef BRANCH_STATS_EN
  logic [31:0]     o_br_count;
  logic [31:0]     o_taken_count;
`endif

  modport master (
`ifdef BRANCH_STATS_EN
    input  o_br_count, o_taken_count,
`endif
    output i_hold, i_id_branch, i_id_rs, i_id_rt, i_rs_data, i_rt_data,
           i_id_pc_plus4, i_id_imm, i_ex_regwrite, i_ex_memread, i_ex_rd,
           i_mem_memread, i_mem_rd,
    input  o_stall, o_pc_sel, o_flush, o_target
  );

  modport slave (
`ifdef BRANCH_STATS_EN
    output o_br_count, o_taken_count,
`endif
    input  i_hold, i_id_branch, i_id_rs, i_id_rt, i_rs_data, i_rt_data,
           i_id_pc_plus4, i_id_imm, i_ex_regwrite, i_ex_memread, i_ex_rd,
           i_mem_memread, i_mem_rd,
    output o_stall, o_pc_sel, o_flush, o_target
  );

endinterface

// File: rtl/branch_compare.sv
// Signed compare of the two branch operands into a relation, then the taken
// decision for the given branch type.
module branch_compare
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      br_type,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            taken
);

  rel_e rel;

  always_comb begin
    rel = REL_GT;
    if ($signed(a) < $signed(b)) rel = REL_LT;
    else if (a == b)             rel = REL_EQ;
  end

  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_BEQ:  taken = (rel == REL_EQ);
      BR_BNE:  taken = (rel != REL_EQ);
      BR_BLEZ: taken = (rel != REL_GT);
      BR_BGTZ: taken = (rel == REL_GT);
      BR_BLTZ: taken = (rel == REL_LT);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// ID-stage branch sequencer: stalls on operand hazards, then resolves the branch
// and drives PC redirect and IF/ID flush. Optional statistics via BRANCH_STATS_EN.
module branch_sequencer
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  branch_sequencer_if.slave bus
);

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            is_branch, uses_rt;
  logic [1:0]      rs_cnt, rt_cnt, req;
  logic [XLEN-1:0] rt_operand;
  logic            cmp_taken;
  logic            stall, resolve, redirect;

  assign is_branch = (bus.i_id_branch != 3'd0) && (bus.i_id_branch <= 3'd5);
  assign uses_rt   = (bus.i_id_branch == BR_BEQ) || (bus.i_id_branch == BR_BNE);

  assign rs_cnt = operand_stalls(bus.i_id_rs, bus.i_ex_regwrite, bus.i_ex_memread,
                                 bus.i_ex_rd, bus.i_mem_memread, bus.i_mem_rd);
  assign rt_cnt = uses_rt ? operand_stalls(bus.i_id_rt, bus.i_ex_regwrite, bus.i_ex_memread,
                                           bus.i_ex_rd, bus.i_mem_memread, bus.i_mem_rd)
                          : 2'd0;
  assign req    = (rs_cnt > rt_cnt) ? rs_cnt : rt_cnt;

  // Single-operand branches compare rs against zero.
  assign rt_operand = uses_rt ? bus.i_rt_data : '0;

  branch_compare #(.XLEN(XLEN)) u_compare (
    .br_type (bus.i_id_branch),
    .a       (bus.i_rs_data),
    .b       (rt_operand),
    .taken   (cmp_taken)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
    end else if (!bus.i_hold) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    resolve = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_branch) begin
          if (req != 2'd0) begin
            stall   = 1'b1;
            cnt_d   = req - 2'd1;
            state_d = (req == 2'd1) ? S_RESOLVE : S_STALL;
          end else begin
            resolve = 1'b1;
          end
        end
      end
      // Hazard inputs are bubbles here; only the counter matters.
      S_STALL: begin
        stall = 1'b1;
        if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        resolve = is_branch;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign redirect     = resolve && cmp_taken && !bus.i_hold && !i_reset;
  assign bus.o_stall  = stall && !i_reset;
  assign bus.o_pc_sel = redirect;
  assign bus.o_flush  = redirect;
  assign bus.o_target = bus.i_id_pc_plus4 + (bus.i_id_imm << 2);

`ifdef BRANCH_STATS_EN
  // Counted once per resolution that actually takes effect (hold low).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bus.o_br_count    <= 32'd0;
      bus.o_taken_count <= 32'd0;
    end else begin
      if (resolve && !bus.i_hold) bus.o_br_count <= bus.o_br_count + 32'd1;
      if (redirect)               bus.o_taken_count <= bus.o_taken_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed self-checking bench for branch_sequencer; statistics checks are
// compiled in only when BRANCH_STATS_EN is defined.
module tb_branch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_br = 0;
  int   exp_taken = 0;

  branch_sequencer_if #(.XLEN(32)) bus ();

  branch_sequencer #(.XLEN(32)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [2:0] outs;
  assign outs = {bus.o_stall, bus.o_pc_sel, bus.o_flush};

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] br, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [31:0] pc, input logic [31:0] imm);
    bus.i_id_branch   = br;
    bus.i_id_rs       = rs;
    bus.i_id_rt       = rt;
    bus.i_rs_data     = rsd;
    bus.i_rt_data     = rtd;
    bus.i_id_pc_plus4 = pc;
    bus.i_id_imm      = imm;
    #1;
  endtask

  task automatic hazards(input logic ex_rw, input logic ex_mr, input logic [4:0] ex_rd,
                         input logic mem_mr, input logic [4:0] mem_rd);
    bus.i_ex_regwrite = ex_rw;
    bus.i_ex_memread  = ex_mr;
    bus.i_ex_rd       = ex_rd;
    bus.i_mem_memread = mem_mr;
    bus.i_mem_rd      = mem_rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_hold = 1'b0;
    hazards(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(3'b001, 5'd1, 5'd2, 32'd5, 32'd5, 32'h100, 32'h4);
    next_cycle();
    checks++;
    if (outs !== 3'b000) begin errors++; $display("[TB] FAIL reset_outputs got %b want 000", outs); end
    rst = 1'b0;
    drive(3'b000, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    checks++;
    if (outs !== 3'b000) begin errors++; $display("[TB] FAIL reset_idle got %b want 000", outs); end
    next_cycle();
    exp_br = 0; exp_taken = 0;
  endtask

  task automatic test_reset_mid_stall();
    hazards(1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
    drive(3'b010, 5'd3, 5'd4, 32'd1, 32'd2, 32'h200, 32'h10);
    checks++;
    if (outs !== 3'b100) begin errors++; $display("[TB] FAIL rms_idle got %b want 100", outs); end
    next_cycle();
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== 3'b000) begin errors++; $display("[TB] FAIL rms_in_reset got %b want 000", outs); end
    next_cycle();
    rst = 1'b0;
    hazards(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(3'b010, 5'd3, 5'd4, 32'd1, 32'd1, 32'h200, 32'h10);
    checks++;
    if (outs !== 3'b000) begin errors++; $display("[TB] FAIL rms_after got %b want 000", outs); end
`ifdef BRANCH_STATS_EN
    checks++;
    if (bus.o_br_count !== 32'd0 || bus.o_taken_count !== 32'd0) begin
      errors++; $display("[TB] FAIL rms_stats got %0d/%0d want 0/0", bus.o_br_count, bus.o_taken_count);
    end
`endif
    exp_br = 1; exp_taken = 0;
    next_cycle();
    drive(3'b000, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    next_cycle();
  endtask

  task automatic test_beq_nohazard();
    drive(3'b001, 5'd1, 5'd2, 32'h5, 32'h5, 32'h100, 32'h4);
    checks++;
    if (outs !== 3'b011) begin errors++; $display("[TB] FAIL beq_outs got %b want 011", outs); end
    checks++;
    if (bus.o_target !== 32'h110) begin errors++; $display("[TB] FAIL beq_target got %h want 00000110", bus.o_target); end
    exp_br++; exp_taken++;
    next_cycle();
    drive(3'b001, 5'd1, 5'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h1);
    checks++;
    if (bus.o_target !== 32'h0) begin errors++; $display("[TB] FAIL target_wrap got %h want 00000000", bus.o_target); end
    exp_br++; exp_taken++;
    next_cycle();
  endtask

  task automatic test_bne_load_stall();
    hazards(1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
    drive(3'b010, 5'd3, 5'd4, 32'h1, 32'h2, 32'h200, 32'h10);
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (outs !== 3'b100) begin errors++; $display("[TB] FAIL bne_stall_c%0d got %b want 100", c, outs); end
      next_cycle();
    end
    checks++;
    if (outs !== 3'b011 || bus.o_target !== 32'h240) begin
      errors++; $display("[TB] FAIL bne_resolve got %b/%h want 011/00000240", outs, bus.o_target);
    end
    exp_br++; exp_taken++;
    next_cycle();
    hazards(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(3'b000, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    checks++;
    if (outs !== 3'b000) begin errors++; $display("[TB] FAIL bne_after got %b want 000", outs); end
    next_cycle();
  endtask

  task automatic test_single_operand();
    logic [2:0]  br  [6] = '{3'b101, 3'b011, 3'b100, 3'b100, 3'b001, 3'b110};
    logic [31:0] rsd [6] = '{32'h80000000, 32'h0, 32'h0, 32'h7FFFFFFF, 32'h0, 32'h0};
    logic [2:0]  exp [6] = '{3'b011, 3'b011, 3'b000, 3'b011, 3'b011, 3'b000};
    // rt=r5 is busy in EX but unused by single-operand branches; rs=r0 never stalls.
    hazards(1'b1, 1'b1, 5'd5, 1'b0, 5'd0);
    for (int k = 0; k < 6; k++) begin
      if (k == 4) hazards(1'b1, 1'b1, 5'd0, 1'b1, 5'd0);
      if (k == 5) hazards(1'b1, 1'b1, 5'd6, 1'b0, 5'd0);
      drive(br[k], (k >= 4) ? 5'd0 : 5'd6, (k == 4) ? 5'd0 : 5'd5, rsd[k], 32'h0, 32'h300, 32'h1);
      if (k == 5) drive(br[k], 5'd6, 5'd6, rsd[k], 32'h0, 32'h300, 32'h1);
      checks++;
      if (outs !== exp[k]) begin errors++; $display("[TB] FAIL single_op_%0d got %b want %b", k, outs, exp[k]); end
      if (k != 5) exp_br++;
      if (exp[k] == 3'b011) exp_taken++;
      next_cycle();
    end
    hazards(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic test_short_stalls();
    // EX ALU result on rs, then MEM load on rt: one stall each.
    for (int k = 0; k < 2; k++) begin
      if (k == 0) hazards(1'b1, 1'b0, 5'd6, 1'b0, 5'd0);
      else        hazards(1'b0, 1'b0, 5'd0, 1'b1, 5'd8);
      drive(3'b001, (k == 0) ? 5'd6 : 5'd7, 5'd8, 32'h9, 32'h9, 32'h400, 32'h8);
      checks++;
      if (outs !== 3'b100) begin errors++; $display("[TB] FAIL short_stall_%0d got %b want 100", k, outs); end
      next_cycle();
      checks++;
      if (outs !== 3'b011) begin errors++; $display("[TB] FAIL short_resolve_%0d got %b want 011", k, outs); end
      exp_br++; exp_taken++;
      next_cycle();
    end
    hazards(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic test_back_to_back();
    drive(3'b001, 5'd1, 5'd2, 32'h3, 32'h3, 32'h300, 32'h2);
    checks++;
    if (outs !== 3'b011 || bus.o_target !== 32'h308) begin
      errors++; $display("[TB] FAIL b2b_first got %b/%h want 011/00000308", outs, bus.o_target);
    end
    exp_br++; exp_taken++;
    next_cycle();
    drive(3'b010, 5'd1, 5'd2, 32'h1, 32'h2, 32'h400, 32'hFFFFFFFF);
    checks++;
    if (outs !== 3'b011 || bus.o_target !== 32'h3FC) begin
      errors++; $display("[TB] FAIL b2b_second got %b/%h want 011/000003fc", outs, bus.o_target);
    end
    exp_br++; exp_taken++;
    next_cycle();
    drive(3'b000, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    next_cycle();
  endtask

  task automatic test_hold();
    int br0;
`ifdef BRANCH_STATS_EN
    br0 = int'(bus.o_br_count);
`else
    br0 = exp_br;
`endif
    bus.i_hold = 1'b1;
    drive(3'b001, 5'd1, 5'd2, 32'h7, 32'h7, 32'h500, 32'h1);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (outs !== 3'b000) begin errors++; $display("[TB] FAIL hold_c%0d got %b want 000", c, outs); end
      next_cycle();
    end
    bus.i_hold = 1'b0;
    #1;
    checks++;
    if (outs !== 3'b011) begin errors++; $display("[TB] FAIL hold_release got %b want 011", outs); end
    exp_br++; exp_taken++;
    next_cycle();
`ifdef BRANCH_STATS_EN
    checks++;
    if (bus.o_br_count !== 32'(br0 + 1)) begin
      errors++; $display("[TB] FAIL hold_br_count got %0d want %0d", bus.o_br_count, br0 + 1);
    end
`endif
    drive(3'b000, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    next_cycle();
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    checks++;
    if (bus.o_br_count !== 32'(exp_br) || bus.o_taken_count !== 32'(exp_taken)) begin
      errors++; $display("[TB] FAIL stats_running got %0d/%0d want %0d/%0d",
                         bus.o_br_count, bus.o_taken_count, exp_br, exp_taken);
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive(3'b001, 5'd1, 5'd2, 32'h4, 32'h4, 32'h100, 32'h1);
    next_cycle();
    drive(3'b001, 5'd1, 5'd2, 32'h1, 32'h2, 32'h100, 32'h1);
    next_cycle();
    hazards(1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
    drive(3'b010, 5'd3, 5'd4, 32'h1, 32'h2, 32'h100, 32'h1);
    next_cycle();
    next_cycle();
    checks++;
    if (bus.o_br_count !== 32'd2) begin errors++; $display("[TB] FAIL stats_mid_stall got %0d want 2", bus.o_br_count); end
    next_cycle();
    hazards(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(3'b100, 5'd1, 5'd0, 32'h0, 32'h0, 32'h100, 32'h1);
    next_cycle();
    drive(3'b101, 5'd1, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h100, 32'h1);
    next_cycle();
    drive(3'b000, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    checks++;
    if (bus.o_br_count !== 32'd5 || bus.o_taken_count !== 32'd3) begin
      errors++; $display("[TB] FAIL stats_five got %0d/%0d want 5/3", bus.o_br_count, bus.o_taken_count);
    end
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_stall();
    test_beq_nohazard();
    test_bne_load_stall();
    test_single_operand();
    test_short_stalls();
    test_back_to_back();
    test_hold();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Sequences branch resolution in the ID stage of the pipelined CPU. It detects when a branch's source operands are still being produced by in-flight instructions and stalls the front end for a fixed number of cycles. It then resolves the branch condition, and on a taken branch drives the PC redirect and the IF/ID flush. It sits between the decoder/register-file read path and the PC / IF-ID pipeline register control.

## Interface
Parameters:
- `XLEN`, default 32: data and PC width.

Ports:
- `i_clk`  in  1  clock. All state updates on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_hold`  in  1  global pipeline freeze (memory stall). While high, the block's state is frozen.
- `i_id_branch`  in  3  branch type in ID:
  - 000 none
  - 001 beq
  - 010 bne
  - 011 blez
  - 100 bgtz
  - 101 bltz
  - 110/111 none
- `i_id_rs`, `i_id_rt`  in  5  source register numbers.
- `i_rs_data`, `i_rt_data`  in  XLEN  operand values, after the external forwarding mux.
- `i_id_pc_plus4`  in  XLEN  PC+4 of the branch.
- `i_id_imm`  in  XLEN  sign-extended word offset.
- `i_ex_regwrite`, `i_ex_memread`  in  1  ID/EX control bits.
- `i_ex_rd`  in  5  ID/EX destination register.
- `i_mem_memread`  in  1  EX/MEM load flag.
- `i_mem_rd`  in  5  EX/MEM destination register.
- `o_stall`  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- `o_pc_sel`  out  1  select `o_target` as the next PC.
- `o_flush`  out  1  clear IF/ID at the next edge.
- `o_target`  out  XLEN  branch target.
- `o_br_count`, `o_taken_count`  out  32  statistics. Present only with `BRANCH_STATS_EN`.

## Operation
- **Operand set:** rs for all branch types; rt additionally for beq/bne. Register 0 never causes a hazard.
- **Required stall count per operand r:**
  - If `i_ex_regwrite && i_ex_rd==r`: 2 when `i_ex_memread` is set, else 1.
  - Else if `i_mem_memread && i_mem_rd==r`: 1.
  - Else 0.
  - The required count is the maximum over the operand set.
- **Relation:** rs vs rt for beq/bne; rs vs 0 for blez/bgtz/bltz. The compare is signed XLEN. Encoding: 00 less, 01 equal, 10 greater.
- **Taken conditions:**
  - beq: equal.
  - bne: not equal.
  - blez: not greater.
  - bgtz: greater.
  - bltz: less.
- **Target:** `o_target = i_id_pc_plus4 + (i_id_imm << 2)`, truncated to XLEN (wraps). Driven combinationally at all times.
- **FSM states:** S_IDLE, S_STALL, S_RESOLVE. A 2-bit down-counter `cnt` accompanies the FSM.
- **S_IDLE:**
  - Branch with count > 0: `o_stall=1`, load `cnt=count-1`.
    - If `cnt` is 0, go to S_RESOLVE; otherwise go to S_STALL.
  - Branch with count = 0: resolve this cycle.
  - No branch: all outputs 0.
- **S_STALL:**
  - `o_stall=1`. Hazard inputs are ignored because they hold bubbles.
  - Decrement `cnt`. When `cnt==0`, go to S_RESOLVE.
- **S_RESOLVE:** resolve, then return to S_IDLE. Hazard inputs are not re-checked.
- **Resolve:** if the branch is taken, `o_pc_sel=1` and `o_flush=1` in that cycle; `o_stall=0`.
- **i_hold high:**
  - State and `cnt` are frozen.
  - `o_pc_sel`, `o_flush` and the statistics updates are suppressed; resolution repeats on the first cycle with hold low.
  - `o_stall` keeps its state-derived value.
- **Reset:** state S_IDLE, `cnt=0`. `o_stall`, `o_pc_sel` and `o_flush` are 0; the statistics counters are 0. Reset asserted mid-stall abandons the branch.

## Timing
- **Decision:** combinational from the ID inputs and the registered state. No registered output.
- **Unhazarded branch:** redirect occurs in the same cycle the branch is in ID. The one wrong-path fetch is flushed at that edge.
- **Stall cycles:** an EX-ALU dependency adds 1 cycle; an EX-load dependency adds 2 cycles; a MEM-load dependency adds 1 cycle. Each stall cycle delays resolution by one cycle.
- **Back-to-back branches:** a branch in ID the cycle after a resolution is evaluated normally from S_IDLE.
- **Inputs during stall:** the ID inputs are held stable by `o_stall`. The block relies on this and does not latch them.

## Configuration
- **`BRANCH_STATS_EN` defined:**
  - `o_br_count` increments once per resolution, not per stall cycle.
  - `o_taken_count` increments once per taken resolution.
  - Both are 32-bit and wrap at 0xFFFFFFFF → 0.
- **`BRANCH_STATS_EN` undefined:** the ports and counters are absent. All other behaviour is identical.

## Structure
- **Package `branch_pkg`:** branch-type codes, relation codes (REL_LT/EQ/GT), FSM state encodings.
- **Sub-module `branch_compare`:** combinational signed compare producing the relation, plus the taken decision from the branch type. It is instantiated once.

## Test plan
- beq, rs=rt=0x5, no hazard, pc_plus4=0x100, imm=0x4 → same cycle `o_pc_sel=1`, `o_flush=1`, `o_target=0x110`, `o_stall=0`.
- bne, rs=r3, EX stage is a load to r3 → `o_stall=1` for 2 cycles; 3rd cycle resolves with rs=0x1, rt=0x2 → `o_pc_sel=1`.
- bltz rs=0x80000000 → taken; blez rs=0 → taken; bgtz rs=0 → not taken (`o_pc_sel=0`, `o_flush=0`).
- Taken beq with `i_hold=1` for 3 cycles → `o_pc_sel=0` throughout; first cycle with hold low → `o_pc_sel=1`; `o_br_count` +1 only.
- `i_reset` pulsed during the 1st S_STALL cycle → next cycle `o_stall=0`, state S_IDLE, counters 0.
- With `BRANCH_STATS_EN`, 5 branches (3 taken, one of which stalled 2 cycles) → `o_br_count=5`, `o_taken_count=3`.
